// File: rtl/si_bomb_pkg.sv
`default_nettype none
//==============================================================================
// Module : si_bomb_pkg
// Desc   : Shared constants and shot-bus slicing for the alien-bomb playfield.
// Rev    : 1.0 - initial release
//==============================================================================
package si_bomb_pkg;

    localparam int c_ROWS             = 7;
    localparam int c_WIDTH            = 8;
    localparam int c_TICK_DIV_DEFAULT = 2500000;

    // Row k (1 = bottom .. 7 = top) sits at bits [k*width-1 : (k-1)*width].
    function automatic int shot_lsb(input int row, input int width);
        return (row - 1) * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/si_bomb_prescaler.sv
`default_nettype none
//==============================================================================
// Module : si_bomb_prescaler
// Desc   : Free-running 0..TICK_DIV-1 counter; o_step marks the last count.
// Rev    : 1.0 - initial release
//==============================================================================
module si_bomb_prescaler #(
    parameter int TICK_DIV = 2500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_step
);

    localparam int             c_CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(TICK_DIV - 1);

    logic [c_CW-1:0] r_count;

    assign o_step = (r_count == c_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (o_step) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/si_register_bomb.sv
`default_nettype none
//==============================================================================
// Module : si_register_bomb
// Desc   : Seven-row falling-bomb register with drop handshake, bullet
//          annihilation and player-hit detection.
// Rev    : 1.0 - initial release
//==============================================================================
module si_register_bomb
    import si_bomb_pkg::*;
#(
    parameter int TICK_DIV = c_TICK_DIV_DEFAULT,
    parameter int WIDTH    = c_WIDTH
) (
    input  logic                     REGISTER_BOMB_CLOCK_50,
    input  logic                     REGISTER_BOMB_RESET_InLow,
    input  logic                     REGISTER_BOMB_Clear_InLow,
    input  logic                     REGISTER_BOMB_Drop_InLow,
    input  logic [WIDTH-1:0]         REGISTER_BOMB_DropCol_InBus,
    output logic                     REGISTER_BOMB_DropAck_Out,
    input  logic [c_ROWS*WIDTH-1:0]  REGISTER_BOMB_SHOOT_InBus,
    input  logic [WIDTH-1:0]         REGISTER_BOMB_Player_InBus,
    output logic [WIDTH-1:0]         REGISTER_BOMB_FILA7_BUS,
    output logic [WIDTH-1:0]         REGISTER_BOMB_FILA6_BUS,
    output logic [WIDTH-1:0]         REGISTER_BOMB_FILA5_BUS,
    output logic [WIDTH-1:0]         REGISTER_BOMB_FILA4_BUS,
    output logic [WIDTH-1:0]         REGISTER_BOMB_FILA3_BUS,
    output logic [WIDTH-1:0]         REGISTER_BOMB_FILA2_BUS,
    output logic [WIDTH-1:0]         REGISTER_BOMB_FILA1_BUS,
    output logic                     REGISTER_BOMB_Step_Out,
    output logic                     REGISTER_BOMB_Hit_Out,
    output logic                     REGISTER_BOMB_Collide_Out
);

    logic             w_step;
    logic             w_accept;
    logic             w_collide;
    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_shot    [c_ROWS];
    logic [WIDTH-1:0] w_shifted [c_ROWS];
    logic [WIDTH-1:0] r_rows    [c_ROWS];   // index 0 = FILA1 (bottom)
    logic [WIDTH-1:0] r_pend_mask;
    logic             r_pend;
    logic             r_ack;
    logic             r_step;
    logic             r_hit;
    logic             r_collide;

    si_bomb_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .i_clk   (REGISTER_BOMB_CLOCK_50),
        .i_rst_n (REGISTER_BOMB_RESET_InLow),
        .o_step  (w_step)
    );

    for (genvar k = 0; k < c_ROWS; k++) begin : g_shot
        assign w_shot[k] = REGISTER_BOMB_SHOOT_InBus[shot_lsb(k + 1, WIDTH) +: WIDTH];
    end

    // Blocking on r_ack keeps a still-low request from being taken twice.
    assign w_accept = !REGISTER_BOMB_Drop_InLow && !r_pend && !r_ack;
    assign w_top    = r_pend   ? r_pend_mask :
                      w_accept ? REGISTER_BOMB_DropCol_InBus : '0;

    always_comb begin
        w_collide = 1'b0;
        for (int k = 0; k < c_ROWS; k++) begin
            w_shifted[k] = r_rows[k];
        end
        if (w_step) begin
            for (int k = 0; k < c_ROWS - 1; k++) begin
                w_shifted[k] = r_rows[k + 1];
            end
            w_shifted[c_ROWS-1] = w_top;
        end
        for (int k = 0; k < c_ROWS; k++) begin
            w_collide = w_collide | (|(w_shifted[k] & w_shot[k]));
        end
    end

    always_ff @(posedge REGISTER_BOMB_CLOCK_50) begin
        if (!REGISTER_BOMB_RESET_InLow) begin
            for (int k = 0; k < c_ROWS; k++) begin
                r_rows[k] <= '0;
            end
            r_pend_mask <= '0;
            r_pend      <= 1'b0;
            r_ack       <= 1'b0;
            r_step      <= 1'b0;
            r_hit       <= 1'b0;
            r_collide   <= 1'b0;
        end else begin
            r_step <= w_step;
            if (!REGISTER_BOMB_Clear_InLow) begin
                for (int k = 0; k < c_ROWS; k++) begin
                    r_rows[k] <= '0;
                end
                r_pend_mask <= '0;
                r_pend      <= 1'b0;
                r_ack       <= 1'b0;
                r_hit       <= 1'b0;
                r_collide   <= 1'b0;
            end else begin
                for (int k = 0; k < c_ROWS; k++) begin
                    r_rows[k] <= w_shifted[k] & ~w_shot[k];
                end
                r_collide <= w_collide;
                r_ack     <= w_accept;
                r_hit     <= w_step & (|(r_rows[0] & REGISTER_BOMB_Player_InBus));
                if (w_step) begin
                    r_pend      <= 1'b0;
                    r_pend_mask <= '0;
                end else if (w_accept) begin
                    r_pend      <= 1'b1;
                    r_pend_mask <= REGISTER_BOMB_DropCol_InBus;
                end
            end
        end
    end

    assign REGISTER_BOMB_FILA1_BUS   = r_rows[0];
    assign REGISTER_BOMB_FILA2_BUS   = r_rows[1];
    assign REGISTER_BOMB_FILA3_BUS   = r_rows[2];
    assign REGISTER_BOMB_FILA4_BUS   = r_rows[3];
    assign REGISTER_BOMB_FILA5_BUS   = r_rows[4];
    assign REGISTER_BOMB_FILA6_BUS   = r_rows[5];
    assign REGISTER_BOMB_FILA7_BUS   = r_rows[6];
    assign REGISTER_BOMB_DropAck_Out = r_ack;
    assign REGISTER_BOMB_Step_Out    = r_step;
    assign REGISTER_BOMB_Hit_Out     = r_hit;
    assign REGISTER_BOMB_Collide_Out = r_collide;

endmodule
`default_nettype wire

// File: tb/tb_si_register_bomb.sv
`default_nettype none
//==============================================================================
// Module : tb_si_register_bomb
// Desc   : Directed and random checks of si_register_bomb against a
//          whole-playfield reference model.
// Rev    : 1.0 - initial release
//==============================================================================
module tb_si_register_bomb;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst_n, clr_n, drop_n;
    logic [7:0]  dropcol, player;
    logic [55:0] shot;
    logic        ack, step, hit, col;
    logic [7:0]  f1, f2, f3, f4, f5, f6, f7;
    logic [55:0] field;

    always #5 clk = ~clk;
    assign field = {f7, f6, f5, f4, f3, f2, f1};

    si_register_bomb #(.TICK_DIV(TD), .WIDTH(8)) dut (
        .REGISTER_BOMB_CLOCK_50      (clk),
        .REGISTER_BOMB_RESET_InLow   (rst_n),
        .REGISTER_BOMB_Clear_InLow   (clr_n),
        .REGISTER_BOMB_Drop_InLow    (drop_n),
        .REGISTER_BOMB_DropCol_InBus (dropcol),
        .REGISTER_BOMB_DropAck_Out   (ack),
        .REGISTER_BOMB_SHOOT_InBus   (shot),
        .REGISTER_BOMB_Player_InBus  (player),
        .REGISTER_BOMB_FILA7_BUS     (f7),
        .REGISTER_BOMB_FILA6_BUS     (f6),
        .REGISTER_BOMB_FILA5_BUS     (f5),
        .REGISTER_BOMB_FILA4_BUS     (f4),
        .REGISTER_BOMB_FILA3_BUS     (f3),
        .REGISTER_BOMB_FILA2_BUS     (f2),
        .REGISTER_BOMB_FILA1_BUS     (f1),
        .REGISTER_BOMB_Step_Out      (step),
        .REGISTER_BOMB_Hit_Out       (hit),
        .REGISTER_BOMB_Collide_Out   (col)
    );

    // Reference: the playfield as one 56-bit word, top row in the high byte.
    logic [55:0] m_field = '0;
    logic [7:0]  m_pmask = '0;
    bit          m_pend = 0, m_ack = 0, m_step = 0, m_hit = 0, m_col = 0;
    int          m_cnt = 0;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          rec_on   = 0;
    logic [7:0]  q_top[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [55:0] nf;
        logic [7:0]  top;
        bit          take, st, h;
        if (!rst_n) begin
            m_field = '0; m_pmask = '0; m_pend = 0; m_ack = 0;
            m_step = 0; m_hit = 0; m_col = 0; m_cnt = 0;
        end else begin
            st     = (m_cnt == TD - 1);
            m_cnt  = (m_cnt + 1) % TD;
            m_step = st;
            if (!clr_n) begin
                m_field = '0; m_pmask = '0; m_pend = 0; m_ack = 0; m_hit = 0; m_col = 0;
            end else begin
                take = !drop_n && !m_pend && !m_ack;
                nf   = m_field;
                h    = 0;
                if (st) begin
                    h      = |(m_field[7:0] & player);
                    top    = m_pend ? m_pmask : (take ? dropcol : 8'h00);
                    nf     = {top, m_field[55:8]};
                    m_pend = 0;
                    m_pmask = '0;
                end else if (take) begin
                    m_pend  = 1;
                    m_pmask = dropcol;
                end
                m_col   = |(nf & shot);
                m_field = nf & ~shot;
                m_ack   = take;
                m_hit   = h;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check("rows", field, m_field);
        check("ack", ack, m_ack);
        check("step", step, m_step);
        check("hit", hit, m_hit);
        check("collide", col, m_col);
        if (rec_on && step) q_top.push_back(f7);
    endtask

    task automatic wait_step();
        int t;
        t = 0;
        do begin
            tick();
            t++;
        end while (!step && t < 3 * TD);
        check("wait_step_timeout", step, 1);
    endtask

    task automatic do_drop(input logic [7:0] m);
        int t;
        bit got;
        t = 0; got = 0;
        drop_n = 0; dropcol = m;
        while (!got && t < 5 * TD) begin
            tick();
            t++;
            got = ack;
        end
        check("drop_ack_timeout", got, 1);
        drop_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, last, t, hits, cols, a1, a2;
        bit b1, b2;

        // Reset with a request already pending on the inputs
        rst_n = 0; clr_n = 1; drop_n = 0; dropcol = 8'hFF; shot = '0; player = 8'h00;
        repeat (3) begin
            tick();
            check("reset_no_ack", ack, 0);
            check("reset_rows_zero", field, 0);
        end
        rst_n = 1;
        tick(); b1 = ack;
        tick(); b2 = ack;
        check("ack_after_reset", b1 | b2, 1);
        drop_n = 1;
        repeat (40) tick();

        // Drop and fall
        wait_step();
        do_drop(8'h18);
        s = 0; last = -1; t = 0;
        while (s < 8 && t < 60) begin
            tick(); t++;
            if (step) begin
                s++;
                if (last >= 0) check("step_period", cyc - last, TD);
                last = cyc;
                if (s == 1) check("fall_f7", f7, 8'h18);
                if (s == 4) check("fall_f4", f4, 8'h18);
                if (s == 7) check("fall_f1", f1, 8'h18);
                if (s == 8) check("fall_empty", field, 0);
            end
        end
        check("fall_step_count", s, 8);

        // Hit over the player, then miss
        player = 8'h01;
        wait_step();
        do_drop(8'h01);
        hits = 0;
        repeat (40) begin
            tick();
            if (hit) begin
                hits++;
                check("hit_with_step", step, 1);
                check("hit_f1_empty", f1, 0);
            end
        end
        check("hit_count", hits, 1);
        player = 8'h02;
        wait_step();
        do_drop(8'h01);
        hits = 0;
        repeat (40) begin tick(); if (hit) hits++; end
        check("miss_count", hits, 0);

        // Annihilation on row 4 with the player under the bomb
        player = 8'h20;
        wait_step();
        do_drop(8'h20);
        t = 0;
        while (f4 !== 8'h20 && t < 40) begin tick(); t++; end
        check("annih_reach_f4", f4, 8'h20);
        shot[31:24] = 8'h20;
        tick();
        shot = '0;
        check("annih_f4", f4, 0);
        check("annih_collide", col, 1);
        hits = 0; cols = 0;
        repeat (40) begin tick(); if (hit) hits++; if (col) cols++; end
        check("annih_no_hit", hits, 0);
        check("annih_single_collide", cols, 0);

        // Handshake: two drops held back to back
        player = 8'h00;
        wait_step();
        q_top.delete();
        rec_on = 1;
        drop_n = 0; dropcol = 8'h81;
        t = 0;
        do begin tick(); t++; end while (!ack && t < 10);
        a1 = cyc;
        dropcol = 8'h42;
        t = 0;
        do begin tick(); t++; end while (!ack && t < 10);
        a2 = cyc;
        drop_n = 1;
        check("ack_spacing", a2 - a1, TD);
        wait_step();
        rec_on = 0;
        check("f7_seq_len", q_top.size(), 2);
        if (q_top.size() >= 2) begin
            check("f7_seq_0", q_top[0], 8'h81);
            check("f7_seq_1", q_top[1], 8'h42);
        end

        // Request landing exactly on a step loads straight into FILA7
        repeat (TD - 1) tick();
        drop_n = 0; dropcol = 8'h3C;
        tick();
        drop_n = 1;
        check("direct_ack", ack, 1);
        check("direct_step", step, 1);
        check("direct_f7", f7, 8'h3C);

        // Clear mid-flight with a pending drop
        player = 8'hFF;
        wait_step();
        do_drop(8'h55);
        clr_n = 0;
        tick();
        clr_n = 1;
        check("clear_rows", field, 0);
        check("clear_hit", hit, 0);
        check("clear_collide", col, 0);
        t = 0;
        do begin tick(); t++; end while (!step && t < 10);
        check("clear_phase", t, TD - 2);
        check("clear_still_empty", field, 0);

        // Random traffic
        repeat (400) begin
            if (drop_n && ($urandom % 6 == 0)) begin
                drop_n = 0;
                dropcol = 8'($urandom);
            end
            for (int k = 0; k < 7; k++)
                shot[k*8 +: 8] = ($urandom % 8 == 0) ? 8'($urandom) : 8'h00;
            player = 8'(1 << ($urandom % 8));
            clr_n  = ($urandom % 50 != 0);
            tick();
            if (ack) drop_n = 1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/si_register_bomb.md
# si_register_bomb

Alien-bomb playfield register for Space Invaders: seven 8-column rows in which bombs travel downward, the counterpart of the player-shot register whose bullets travel upward. A drop request from the alien controller injects a column mask into the top row (FILA7). A prescaled step tick shifts every row one row down. Bombs are annihilated where they coincide with a player bullet, and a hit is flagged when a bomb leaves the bottom row (FILA1) over the player's column. The block feeds the display matrix and the game-state FSM.

## Interface
Parameters:
- `TICK_DIV`, default 2500000: clocks per bomb step (20 steps/s at 50 MHz); legal range ≥ 2.
- `WIDTH`, default 8: columns per row.

Ports:
- `REGISTER_BOMB_CLOCK_50`  in  1  system clock, 50 MHz.
- `REGISTER_BOMB_RESET_InLow`  in  1  one clock; reset is synchronous and active-low.
- `REGISTER_BOMB_Clear_InLow`  in  1  synchronous clear of the playfield, active-low.
- `REGISTER_BOMB_Drop_InLow`  in  1  drop request, active-low; held until acknowledged.
- `REGISTER_BOMB_DropCol_InBus`  in  8  column mask of bombs to inject.
- `REGISTER_BOMB_DropAck_Out`  out  1  one-cycle pulse: request accepted.
- `REGISTER_BOMB_SHOOT_InBus`  in  56  player-shot rows, packed; bits [8k-1:8k-8] = shot FILAk, k = 1..7.
- `REGISTER_BOMB_Player_InBus`  in  8  player column mask (bottom row).
- `REGISTER_BOMB_FILA7_BUS` … `REGISTER_BOMB_FILA1_BUS`  out  8 each  bomb rows; FILA7 is the top row.
- `REGISTER_BOMB_Step_Out`  out  1  one-cycle pulse on every step.
- `REGISTER_BOMB_Hit_Out`  out  1  one-cycle pulse: a bomb exited over the player.
- `REGISTER_BOMB_Collide_Out`  out  1  one-cycle pulse: at least one bomb/bullet annihilation this cycle.

## Operation
- **Reset:** all rows = 0, pending mask = 0, pending flag = 0, prescaler = 0. DropAck, Step, Hit and Collide = 0.
- **Priority:** reset > clear > normal operation.
- **Clear:** rows, pending mask and pending flag go to 0. Outputs are 0 the next cycle. The prescaler keeps counting. No Hit, Ack or Collide pulse is generated in a clear cycle.
- **Prescaler:** counts 0..TICK_DIV-1 and wraps. step = (count == TICK_DIV-1).
- **Drop handshake**, accept condition: Drop_InLow = 0 and pending flag = 0 and DropAck not asserted this cycle.
  - On accept: pending mask ← DropCol, pending flag ← 1, DropAck = 1 on the next cycle.
  - A request seen while pending = 1 is not accepted; the requester keeps Drop_InLow low.
  - If accept and step occur in the same cycle, DropCol goes straight into FILA7, pending stays 0, and Ack still pulses.
  - DropCol = 0 is accepted and acknowledged; it injects nothing.
- **Step cycle:**
  - FILA1 ← FILA2, …, FILA6 ← FILA7, FILA7 ← pending mask (or the direct DropCol), and pending is cleared.
  - The departing FILA1 is discarded. Hit = |(FILA1 & Player) evaluated on the pre-shift FILA1, registered, and visible one cycle after the step.
- **Annihilation:** applies every cycle, including step cycles. Each stored bit becomes new_k & ~shot_k, where new_k is the shifted-in or held value of row k and shot_k is the same-cycle shot row k. Collide = |(new_k & shot_k) over all k, registered.
- The block never modifies the shot register; the game FSM removes bullets using Collide.

## Timing
- Every output is registered and changes only on the clock edge.
- Drop-to-visible latency: from Ack to the next step edge, at most TICK_DIV cycles. A bomb crosses all 7 rows in 7·TICK_DIV cycles.
- Step_Out is high in the cycle after the internal step edge, so it is aligned with the updated rows.
- Hit_Out and Collide_Out are aligned with Step_Out when caused by a step.
- Back-to-back drops: one accept per step period, at most. A second request waits until pending clears at the step.
- Reset or clear with a request held low: accept can occur from the first cycle after reset/clear deasserts.

## Structure
- Package `si_bomb_pkg`: constants ROWS = 7, WIDTH = 8, default TICK_DIV, and the shot-bus slicing offsets.
- Sub-module `si_bomb_prescaler`: parameterised counter with synchronous active-low reset and a step output. Its width is $clog2(TICK_DIV).
- Top level: row array, pending register, handshake logic, and registered flag outputs. Target 150–250 lines.

## Test plan
All scenarios use TICK_DIV = 4.
- **Reset:** hold reset for 3 cycles, with Drop_InLow = 0 and DropCol = 8'hFF → all rows 0 and no Ack during reset. Ack is high in the first or second cycle after release.
- **Drop and fall:** drop 8'h18, with no shots and Player = 0 → FILA7 = 8'h18 after the next step. The mask then moves down one row per 4 cycles; FILA1 = 8'h18 after 7 steps and all rows are 0 after 8 steps. Step_Out pulses every 4 cycles.
- **Hit:** drop 8'h01 with Player = 8'h01 → Hit_Out pulses exactly once, together with the Step_Out that empties FILA1. Rerun with Player = 8'h02 → no Hit.
- **Annihilation:** FILA4 = 8'h20 and a shot on row 4 at bit 5 for 1 cycle → FILA4 = 0 on the next edge, Collide pulses once, and no Hit ever occurs.
- **Handshake:** hold Drop low across two step periods with DropCol = 8'h81, then 8'h42 → two Acks, spaced by the step period. FILA7 sequence is 8'h81 then 8'h42. A request coinciding with a step cycle loads directly, with no 4-cycle wait.
- **Clear mid-flight:** rows loaded and pending set, Clear_InLow = 0 for 1 cycle → all rows 0 and no Hit or Collide. The prescaler phase is unchanged (the next Step_Out stays on schedule).
